// File: rtl/reg_writeback.sv
// reg_writeback: register-file write port owner; merges ALU results with FIFO-buffered
// load responses, tracks per-register pending loads, and requests ALU holds on starvation.
`default_nettype none

module reg_writeback #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_hold,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,
  output logic [31:0] busy
);

  localparam logic [3:0] c_starve_lim = 4'(STARVE_LIMIT);

  logic [4:0]  fifo_rd_q   [2];
  logic [31:0] fifo_data_q [2];
  logic [1:0]  count_q, count_d;
  logic        wptr_q, wptr_d;
  logic        rptr_q, rptr_d;
  logic        wr_en_q, wr_en_d;
  logic [4:0]  wr_rd_q, wr_rd_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        wr_is_load_q, wr_is_load_d;
  logic [31:0] busy_q, busy_d;
  logic [3:0]  starve_q, starve_d;
  logic        hold_q, hold_d;
  logic        w_push;
  logic        w_pop;

  // No bypass: readiness depends only on the registered count.
  assign ld_ready = rst & (count_q < 2'd2);
  assign w_push   = ld_valid & ld_ready;
  assign w_pop    = ~alu_valid & (count_q != 2'd0);

  assign alu_hold = hold_q;
  assign wr_en    = wr_en_q;
  assign wr_rd    = wr_rd_q;
  assign wr_data  = wr_data_q;
  assign busy     = busy_q;

  always_comb begin
    count_d      = count_q + {1'b0, w_push} - {1'b0, w_pop};
    wptr_d       = wptr_q ^ w_push;
    rptr_d       = rptr_q ^ w_pop;

    wr_en_d      = 1'b0;
    wr_rd_d      = wr_rd_q;
    wr_data_d    = wr_data_q;
    wr_is_load_d = 1'b0;
    if (alu_valid) begin
      wr_en_d   = (alu_rd != 5'd0);
      wr_rd_d   = alu_rd;
      wr_data_d = alu_data;
    end else if (w_pop) begin
      wr_en_d      = (fifo_rd_q[rptr_q] != 5'd0);
      wr_rd_d      = fifo_rd_q[rptr_q];
      wr_data_d    = fifo_data_q[rptr_q];
      wr_is_load_d = 1'b1;
    end

    // Clear lands on the register-file write edge; a same-cycle new issue wins.
    busy_d = busy_q;
    if (wr_en_q && wr_is_load_q) begin
      busy_d[wr_rd_q] = 1'b0;
    end
    if (issue_valid) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;

    if ((count_q != 2'd0) && !w_pop) begin
      starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
    end else begin
      starve_d = 4'd0;
    end

    hold_d = hold_q;
    if (starve_q >= c_starve_lim) begin
      hold_d = 1'b1;
    end
    if (w_pop) begin
      hold_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q      <= 2'd0;
      wptr_q       <= 1'b0;
      rptr_q       <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_rd_q      <= 5'd0;
      wr_data_q    <= 32'd0;
      wr_is_load_q <= 1'b0;
      busy_q       <= 32'd0;
      starve_q     <= 4'd0;
      hold_q       <= 1'b0;
    end else begin
      count_q      <= count_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      wr_en_q      <= wr_en_d;
      wr_rd_q      <= wr_rd_d;
      wr_data_q    <= wr_data_d;
      wr_is_load_q <= wr_is_load_d;
      busy_q       <= busy_d;
      starve_q     <= starve_d;
      hold_q       <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_rd_q[wptr_q]   <= ld_rd;
      fifo_data_q[wptr_q] <= ld_data;
    end
  end

endmodule

`default_nettype wire
